// File: rtl/pe_arr_seq_if.sv
// Job, buffer-read and array-drive signals of the PE array sequencer.
// master: the sequencer side; slave: scheduler/buffer/array side.
interface pe_arr_seq_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = 8,
  parameter int KMAX = 256,
  parameter int KW   = $clog2(KMAX + 1),
  parameter int AW   = $clog2(KMAX)
);
  logic                 start;
  logic                 abort;
  logic [KW-1:0]        k_len;
  logic                 busy;
  logic                 done;
  logic                 w_rd_en;
  logic                 a_rd_en;
  logic [AW-1:0]        rd_addr;
  logic [COLS*DW-1:0]   w_rd_data;
  logic [ROWS*DW-1:0]   a_rd_data;
  logic                 arr_clr;
  logic                 arr_fire;
  logic [COLS*DW-1:0]   arr_w;
  logic [ROWS*DW-1:0]   arr_a;

  modport master (
    input  start, abort, k_len, w_rd_data, a_rd_data,
    output busy, done, w_rd_en, a_rd_en, rd_addr, arr_clr, arr_fire, arr_w, arr_a
  );

  modport slave (
    output start, abort, k_len, w_rd_data, a_rd_data,
    input  busy, done, w_rd_en, a_rd_en, rd_addr, arr_clr, arr_fire, arr_w, arr_a
  );
endinterface

// File: rtl/pe_arr_seq.sv
// Tile-job sequencer for a ROWSxCOLS systolic PE array: clears the array, streams k_len
// operand vectors from the buffers with diagonal skew, drains the pipeline, pulses done.
module pe_arr_seq #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = 8,
  parameter int KMAX = 256
) (
  input logic          clk,
  input logic          rstn,
  pe_arr_seq_if.master bus
);
  localparam int KW  = $clog2(KMAX + 1);
  localparam int AW  = $clog2(KMAX);
  localparam int DRN = ROWS + COLS - 1;
  localparam int DCW = $clog2(DRN + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_lat;
  logic [KW-1:0]       feed_cnt;
  logic [DCW-1:0]      drain_cnt;
  logic                zero_done;
  logic                rd_vld_p0;
  logic                accept;
  logic                abort_act;
  logic                busy, done, rd_en, arr_clr, arr_fire;
  logic [AW-1:0]       rd_addr;
  logic [ROWS*DW-1:0]  a_p0, arr_a;
  logic [COLS*DW-1:0]  w_p0, arr_w;

  function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
    return (k > KW'(KMAX)) ? KW'(KMAX) : k;
  endfunction

  assign accept    = (state_q == IDLE) && bus.start && !bus.abort;
  assign abort_act = bus.abort && (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    arr_clr  = 1'b0;
    arr_fire = 1'b0;
    done     = zero_done;
    case (state_q)
      IDLE: begin
        if (accept && (bus.k_len != '0)) state_d = CLEAR;
      end
      CLEAR: begin
        busy    = 1'b1;
        arr_clr = 1'b1;
        state_d = abort_act ? IDLE : FEED;
      end
      FEED: begin
        busy     = 1'b1;
        rd_en    = 1'b1;
        rd_addr  = feed_cnt[AW-1:0];
        arr_fire = (feed_cnt != '0);
        if (abort_act)                           state_d = IDLE;
        else if ((feed_cnt + KW'(1)) == k_lat)   state_d = DRAIN;
      end
      DRAIN: begin
        busy     = 1'b1;
        arr_fire = 1'b1;
        if (abort_act)                           state_d = IDLE;
        else if (drain_cnt == DCW'(DRN - 1))     state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      k_lat     <= '0;
      feed_cnt  <= '0;
      drain_cnt <= '0;
      zero_done <= 1'b0;
      rd_vld_p0 <= 1'b0;
    end else begin
      state_q   <= state_d;
      feed_cnt  <= (state_q == FEED  && state_d == FEED)  ? feed_cnt + KW'(1)   : '0;
      drain_cnt <= (state_q == DRAIN && state_d == DRAIN) ? drain_cnt + DCW'(1) : '0;
      if (accept) k_lat <= clamp_k(bus.k_len);
      zero_done <= accept && (bus.k_len == '0);
      rd_vld_p0 <= (state_q == FEED) && !bus.abort;
    end
  end

  // p0: buffer data returns one cycle after the strobe; masked so idle slots carry zeros
  assign a_p0 = rd_vld_p0 ? bus.a_rd_data : '0;
  assign w_p0 = rd_vld_p0 ? bus.w_rd_data : '0;

  for (genvar i = 0; i < ROWS; i++) begin : g_a
    if (i == 0) begin : g_lane0
      assign arr_a[DW-1:0] = a_p0[DW-1:0];
    end else begin : g_dly
      logic [DW-1:0] sr_p [i];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int s = 0; s < i; s++) sr_p[s] <= '0;
        end else if (abort_act) begin
          for (int s = 0; s < i; s++) sr_p[s] <= '0;
        end else begin
          sr_p[0] <= a_p0[i*DW +: DW];
          for (int s = 1; s < i; s++) sr_p[s] <= sr_p[s-1];
        end
      end
      assign arr_a[i*DW +: DW] = sr_p[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_w
    if (j == 0) begin : g_lane0
      assign arr_w[DW-1:0] = w_p0[DW-1:0];
    end else begin : g_dly
      logic [DW-1:0] sr_p [j];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int s = 0; s < j; s++) sr_p[s] <= '0;
        end else if (abort_act) begin
          for (int s = 0; s < j; s++) sr_p[s] <= '0;
        end else begin
          sr_p[0] <= w_p0[j*DW +: DW];
          for (int s = 1; s < j; s++) sr_p[s] <= sr_p[s-1];
        end
      end
      assign arr_w[j*DW +: DW] = sr_p[j-1];
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.w_rd_en  = rd_en;
  assign bus.a_rd_en  = rd_en;
  assign bus.rd_addr  = rd_addr;
  assign bus.arr_clr  = arr_clr;
  assign bus.arr_fire = arr_fire;
  assign bus.arr_a    = arr_a;
  assign bus.arr_w    = arr_w;
endmodule
